// File: rtl/game_time_display.sv
// Converts the game clock's tenths count to BCD and scans it onto a 4-digit active-low 7-segment display.
// Latency: 12 cycles from new COUNT_IN to BCD_VALID; display lags index/BCD by one cycle. No backpressure; input changes mid-conversion are resampled in IDLE.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module game_time_display #(
    parameter int SCAN_DIV = 10000
) (
    input  logic        CLOCK10M,
    input  logic        RST_N,
    input  logic [9:0]  COUNT_IN,
    output logic [15:0] BCD_OUT,
    output logic        BCD_VALID,
    output logic [3:0]  DIGIT_SEL,
    output logic [6:0]  SEG_OUT,
    output logic        DP_OUT
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [9:0]    r_last, w_last_nxt;
    logic [9:0]    r_bin, w_bin_nxt;
    logic [15:0]   r_acc, w_acc_nxt;
    logic [3:0]    r_iter, w_iter_nxt;
    logic [15:0]   r_bcd, w_bcd_nxt;
    logic          r_vld, w_vld_nxt;
    logic [15:0]   w_adj;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_sel;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;

    function automatic logic [15:0] add3(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 4; i++) begin
            if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLOCK10M or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_last  <= '0;
            r_bin   <= '0;
            r_acc   <= '0;
            r_iter  <= '0;
            r_bcd   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_bin   <= w_bin_nxt;
            r_acc   <= w_acc_nxt;
            r_iter  <= w_iter_nxt;
            r_bcd   <= w_bcd_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_bin_nxt   = r_bin;
        w_acc_nxt   = r_acc;
        w_iter_nxt  = r_iter;
        w_bcd_nxt   = r_bcd;
        w_vld_nxt   = 1'b0;
        w_adj       = add3(r_acc);
        case (r_state)
            ST_IDLE: begin
                if (COUNT_IN != r_last) begin
                    w_last_nxt  = COUNT_IN;
                    w_bin_nxt   = COUNT_IN;
                    w_acc_nxt   = '0;
                    w_iter_nxt  = '0;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                // One double-dabble step: correct digits, then shift the binary MSB in.
                w_acc_nxt  = {w_adj[14:0], r_bin[9]};
                w_bin_nxt  = {r_bin[8:0], 1'b0};
                w_iter_nxt = r_iter + 4'd1;
                if (r_iter == 4'd9) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_bcd_nxt   = r_acc;
                w_vld_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK10M or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_comb begin
        w_digit = r_bcd[4*r_idx +: 4];
        w_seg   = seg_decode(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_idx == 2'd3 && r_bcd[15:12] == 4'd0) w_seg = 7'b1111111;
        if (r_idx == 2'd2 && r_bcd[15:8] == 8'd0)  w_seg = 7'b1111111;
`endif
    end

    always_ff @(posedge CLOCK10M or negedge RST_N) begin
        if (!RST_N) begin
            r_sel <= 4'b0001;
            r_seg <= 7'b1000000;
            r_dp  <= 1'b1;
        end else begin
            r_sel <= 4'b0001 << r_idx;
            r_seg <= w_seg;
            r_dp  <= (r_idx != 2'd1);
        end
    end

    assign BCD_OUT   = r_bcd;
    assign BCD_VALID = r_vld;
    assign DIGIT_SEL = r_sel;
    assign SEG_OUT   = r_seg;
    assign DP_OUT    = r_dp;

endmodule

// File: tb/tb_game_time_display.sv
// Directed bench for game_time_display: reset values, conversion timing, mid-conversion changes, scan and async reset.
module tb_game_time_display;

    logic        CLOCK10M;
    logic        RST_N;
    logic [9:0]  COUNT_IN;
    logic [15:0] BCD_OUT;
    logic        BCD_VALID;
    logic [3:0]  DIGIT_SEL;
    logic [6:0]  SEG_OUT;
    logic        DP_OUT;

    int n_checks = 0;
    int n_errors = 0;
    int vld_total = 0;
    int base;
    bit ok;

    game_time_display #(.SCAN_DIV(4)) dut (
        .CLOCK10M (CLOCK10M),
        .RST_N    (RST_N),
        .COUNT_IN (COUNT_IN),
        .BCD_OUT  (BCD_OUT),
        .BCD_VALID(BCD_VALID),
        .DIGIT_SEL(DIGIT_SEL),
        .SEG_OUT  (SEG_OUT),
        .DP_OUT   (DP_OUT)
    );

    initial CLOCK10M = 1'b0;
    always #50 CLOCK10M = ~CLOCK10M;

    always @(negedge CLOCK10M) if (BCD_VALID) vld_total++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK10M);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bcd"},  32'(BCD_OUT),   'h0000);
        chk({tag, "_vld"},  32'(BCD_VALID), 0);
        chk({tag, "_sel"},  32'(DIGIT_SEL), 'b0001);
        chk({tag, "_seg"},  32'(SEG_OUT),   'b1000000);
        chk({tag, "_dp"},   32'(DP_OUT),    1);
    endtask

    // New value applied after an edge is latched at E0 (next edge); BCD_OUT lands at E11.
    task automatic convert(input string tag, input logic [9:0] val, input logic [15:0] prev, input logic [15:0] exp);
        COUNT_IN = val;
        ticks(11);
        chk({tag, "_pre_bcd"}, 32'(BCD_OUT), 32'(prev));
        chk({tag, "_pre_vld"}, 32'(BCD_VALID), 0);
        tick();
        chk({tag, "_bcd"}, 32'(BCD_OUT), 32'(exp));
        chk({tag, "_vld"}, 32'(BCD_VALID), 1);
        tick();
        chk({tag, "_vld_end"}, 32'(BCD_VALID), 0);
    endtask

    initial begin
        RST_N    = 1'b0;
        COUNT_IN = '0;
        ticks(3);
        chk_reset_vals("reset");

        // Release with COUNT_IN = 0: nothing converts.
        @(negedge CLOCK10M);
        RST_N = 1'b1;
        base = vld_total;
        ticks(20);
        chk("idle_zero_no_strobe", 32'(vld_total - base), 0);
        chk("idle_zero_bcd", 32'(BCD_OUT), 'h0000);

        base = vld_total;
        convert("c1023", 10'd1023, 16'h0000, 16'h1023);
        convert("c5", 10'd5, 16'h1023, 16'h0005);
        convert("c100", 10'd100, 16'h0005, 16'h0100);
        ticks(2);
        chk("conv_strobes", 32'(vld_total - base), 3);

        // Input changes to 37 during the conversion of 5.
        base = vld_total;
        COUNT_IN = 10'd5;
        ticks(3);
        COUNT_IN = 10'd37;
        ticks(8);
        chk("mid_pre_bcd", 32'(BCD_OUT), 'h0100);
        tick();
        chk("mid_first_bcd", 32'(BCD_OUT), 'h0005);
        chk("mid_first_vld", 32'(BCD_VALID), 1);
        ticks(11);
        chk("mid_gap_bcd", 32'(BCD_OUT), 'h0005);
        chk("mid_gap_vld", 32'(BCD_VALID), 0);
        tick();
        chk("mid_second_bcd", 32'(BCD_OUT), 'h0037);
        chk("mid_second_vld", 32'(BCD_VALID), 1);
        ticks(5);
        chk("mid_strobes", 32'(vld_total - base), 2);

        // Scan with 123 -> digits {0,1,2,3}.
        COUNT_IN = 10'd123;
        ticks(15);
        chk("scan_bcd", 32'(BCD_OUT), 'h0123);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (DIGIT_SEL == 4'b1000) ok = 1'b1;
        end
        chk("scan_sync_a", 32'(ok), 1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (DIGIT_SEL == 4'b0001) ok = 1'b1;
        end
        chk("scan_sync_b", 32'(ok), 1);
        chk("d0_seg", 32'(SEG_OUT), 'b0110000);
        chk("d0_dp", 32'(DP_OUT), 1);
        ticks(3);
        chk("d0_hold_sel", 32'(DIGIT_SEL), 'b0001);
        tick();
        chk("d1_sel", 32'(DIGIT_SEL), 'b0010);
        chk("d1_seg", 32'(SEG_OUT), 'b0100100);
        chk("d1_dp", 32'(DP_OUT), 0);
        ticks(4);
        chk("d2_sel", 32'(DIGIT_SEL), 'b0100);
        chk("d2_seg", 32'(SEG_OUT), 'b1111001);
        chk("d2_dp", 32'(DP_OUT), 1);
        ticks(4);
        chk("d3_sel", 32'(DIGIT_SEL), 'b1000);
`ifdef LEADING_ZERO_BLANK_EN
        chk("d3_seg", 32'(SEG_OUT), 'b1111111);
`else
        chk("d3_seg", 32'(SEG_OUT), 'b1000000);
`endif
        ticks(4);
        chk("d0_wrap_sel", 32'(DIGIT_SEL), 'b0001);

        // Async reset during conversion of 456.
        COUNT_IN = 10'd456;
        ticks(5);
        base = vld_total;
        #10 RST_N = 1'b0;
        #1;
        chk_reset_vals("arst");
        ticks(3);
        chk("arst_hold_vld", 32'(vld_total - base), 0);
        @(negedge CLOCK10M);
        RST_N = 1'b1;
        ticks(11);
        chk("rest_pre_bcd", 32'(BCD_OUT), 'h0000);
        chk("rest_pre_vld", 32'(BCD_VALID), 0);
        tick();
        chk("rest_bcd", 32'(BCD_OUT), 'h0456);
        chk("rest_vld", 32'(BCD_VALID), 1);
        ticks(2);
        chk("rest_strobes", 32'(vld_total - base), 1);

        // Constant input: no strobes.
        base = vld_total;
        ticks(1000);
        chk("const_no_strobe", 32'(vld_total - base), 0);
        chk("const_bcd", 32'(BCD_OUT), 'h0456);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
